dnn_layer_seq: RTL and testbench
================================

Name: dnn_layer_seq

Overview:
- Parametrised, time-multiplexed fully-connected DNN layer engine: y[j] = sum_i x[i]*w[i][j], for N_IN inputs and N_OUT neurons.
- Successor to the fixed 4-2-2 combinational/pipelined dnn_top.
- Uses one shared signed multiplier-accumulator, a valid/ready input handshake and a streamed, back-pressurable output.
- Instances chain into multi-layer networks; each output stream feeds the next layer's input capture.

Parameters:
- I_W, 5, signed width of each input and weight.
- N_IN, 4, number of inputs per batch (>=1).
- N_OUT, 4, number of neurons/outputs per batch (>=1).
- ACC_W, 2*I_W+$clog2(N_IN), signed accumulator/output width (default 12).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  batch (x and w) present.
- in_ready  out  1  engine idle, will accept a batch.
- in_x  in  N_IN*I_W  packed signed inputs; x[i] = in_x[i*I_W +: I_W].
- in_w  in  N_IN*N_OUT*I_W  packed signed weights; w[i][j] at bit offset (i*N_OUT+j)*I_W.
- out_valid  out  1  out_data holds a finished neuron.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  ACC_W  signed neuron result.
- out_idx  out  $clog2(N_OUT) (min 1)  neuron index j.
- out_last  out  1  high with out_valid for j == N_OUT-1.
- busy  out  1  high in CALC or EMIT.

Behaviour:
- Reset: all outputs 0 except in_ready=1. FSM=IDLE; acc, i, j and the capture registers are all 0.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_x/in_w into internal registers, clear acc, set i=0, j=0, go to CALC. Inputs may change afterwards.
- CALC: each cycle acc <= acc + sext(x[i]*w[i][j]), where the product is a full 2*I_W signed value. After N_IN cycles (i==N_IN-1), go to EMIT.
- EMIT: out_valid=1; out_data=acc, out_idx=j, out_last=(j==N_OUT-1). All three are held stable until out_ready.
  - On handshake with out_last=1: go to IDLE, out_valid drops.
  - Otherwise: j++, clear acc, i=0, go to CALC.
- Latency: out_valid rises N_IN cycles after the accept edge. With out_ready held high, a batch occupies N_OUT*(N_IN+1) cycles. in_ready rises the cycle after the last output handshake (no overlap of batches).
- in_valid while busy: ignored; in_ready=0, no capture.
- out_ready while not out_valid: ignored.
- Arithmetic: two's complement throughout. With the default ACC_W no overflow is possible. A smaller ACC_W wraps silently, with no saturation.
- Reset mid-operation: the partial batch is discarded and outputs return to reset values within the same cycle.
- N_OUT==1: out_idx is 0 and out_last=1 on every output.

Optional Feature:
- DNN_RELU_EN defined: out_data = (acc<0) ? 0 : acc, with ReLU applied at EMIT only; the internal acc stays signed.
- Undefined: out_data = raw acc.
- Timing and handshake are identical in both cases.

Decomposition:
- dnn_pkg: the default parameter constants, the FSM state enum (IDLE, CALC, EMIT) and a clog2-with-min-1 helper function.
- Sub-module dnn_mac_unit (parameters I_W, ACC_W): clear/enable-controlled signed multiply-accumulate register. The FSM, counters and handshake logic stay in dnn_layer_seq.

Test Plan:
- Unit weights: all x=1, all w=1, out_ready=1 -> 4 outputs, each out_data=4, out_idx 0..3, out_last only on idx 3; in_ready high again 20 cycles after accept.
- Extremes: all x=-16, all w=-16 -> every out_data=1024. All x=-16, all w=15 -> every out_data=-960 (with DNN_RELU_EN: 0).
- Mixed: x={3,-2,7,0}, w[i][0]={1,1,1,1}, w[i][1]={-1,2,0,5} -> idx0=8, idx1=-7.
- Back-pressure: out_ready low 5 cycles during EMIT of idx 1 -> out_valid/out_data/out_idx stable throughout; idx 2 follows only after the handshake.
- Busy rejection: new in_valid with different x/w asserted during CALC -> no capture, results match the first batch; the second batch is accepted only when in_ready=1.
- Reset mid-CALC of idx 2: rst pulse -> out_valid=0, busy=0, in_ready=1 immediately; the next batch produces correct fresh results.

Source files
------------

// File: rtl/dnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dnn_pkg
// Description : Shared constants, FSM state encoding and helper function for
//               the time-multiplexed fully-connected layer engine.
// Revision    : 1.0 - initial release
// ============================================================================
package dnn_pkg;

  localparam int DNN_I_W   = 5;
  localparam int DNN_N_IN  = 4;
  localparam int DNN_N_OUT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_EMIT = 2'd2
  } dnn_state_t;

  // Counter/index width that never collapses to zero bits for a count of 1.
  function automatic int clog2m1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dnn_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : dnn_mac_unit
// Description : Signed multiply-accumulate register. Each enabled cycle adds
//               the full-width signed product i_a*i_b (sign-extended or
//               wrapped to ACC_W) to the accumulator. i_clr has priority.
// Ports       : clk, rst (async, active high)
//               i_clr  - synchronous clear of the accumulator
//               i_en   - accumulate enable
//               i_a    - signed multiplicand, I_W bits
//               i_b    - signed multiplier,   I_W bits
//               o_acc  - signed accumulator,  ACC_W bits
// Revision    : 1.0 - initial release
// ============================================================================
module dnn_mac_unit #(
  parameter int I_W   = 5,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [I_W-1:0]   i_a,
  input  logic [I_W-1:0]   i_b,
  output logic [ACC_W-1:0] o_acc
);

  logic signed [2*I_W-1:0] w_prod;
  logic        [ACC_W-1:0] w_prod_ext;
  logic        [ACC_W-1:0] r_acc;

  assign w_prod = $signed(i_a) * $signed(i_b);

  // Fit the 2*I_W product to the accumulator: sign-extend when wider,
  // silently wrap (keep low bits) when narrower.
  generate
    if (ACC_W > 2*I_W) begin : g_sext
      assign w_prod_ext = {{(ACC_W-2*I_W){w_prod[2*I_W-1]}}, w_prod};
    end else if (ACC_W == 2*I_W) begin : g_exact
      assign w_prod_ext = w_prod;
    end else begin : g_wrap
      assign w_prod_ext = w_prod[ACC_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/dnn_layer_seq.sv
`default_nettype none
// ============================================================================
// Module      : dnn_layer_seq
// Description : Time-multiplexed fully-connected layer y[j] = sum_i x[i]*w[i][j]
//               using one shared signed MAC. A batch (x and w) is captured on
//               an in_valid/in_ready handshake; neurons are computed one at a
//               time (N_IN cycles each) and streamed out with a back-
//               pressurable valid/ready interface.
// Option      : define DNN_RELU_EN to clamp negative results to zero on the
//               output only (the accumulator itself stays signed).
// Ports       : clk, rst (async, active high)
//               in_valid/in_ready   - batch handshake, ready only when idle
//               in_x                - packed x[i] at in_x[i*I_W +: I_W]
//               in_w                - packed w[i][j] at (i*N_OUT+j)*I_W
//               out_valid/out_ready - result handshake
//               out_data            - signed neuron result
//               out_idx             - neuron index j
//               out_last            - marks j == N_OUT-1
//               busy                - computing or emitting
// Revision    : 1.0 - initial release
// ============================================================================
module dnn_layer_seq
  import dnn_pkg::*;
#(
  parameter int I_W   = DNN_I_W,
  parameter int N_IN  = DNN_N_IN,
  parameter int N_OUT = DNN_N_OUT,
  parameter int ACC_W = 2*I_W + $clog2(N_IN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_IN*I_W-1:0]         in_x,
  input  logic [N_IN*N_OUT*I_W-1:0]   in_w,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            out_data,
  output logic [clog2m1(N_OUT)-1:0]   out_idx,
  output logic                        out_last,
  output logic                        busy
);

  localparam int I_CW = clog2m1(N_IN);
  localparam int J_CW = clog2m1(N_OUT);
  localparam logic [I_CW-1:0] c_i_last = I_CW'(N_IN - 1);
  localparam logic [J_CW-1:0] c_j_last = J_CW'(N_OUT - 1);

  dnn_state_t                  r_state;
  dnn_state_t                  w_state_nxt;
  logic [N_IN*I_W-1:0]         r_x;
  logic [N_IN*N_OUT*I_W-1:0]   r_w;
  logic [I_CW-1:0]             r_i;
  logic [I_CW-1:0]             w_i_nxt;
  logic [J_CW-1:0]             r_j;
  logic [J_CW-1:0]             w_j_nxt;
  logic                        w_capture;
  logic                        w_mac_clr;
  logic                        w_mac_en;
  logic                        w_j_is_last;
  logic [ACC_W-1:0]            w_acc;
  logic [ACC_W-1:0]            w_emit_data;

  logic [I_W-1:0]              w_x_arr [N_IN];
  logic [I_W-1:0]              w_w_arr [N_IN][N_OUT];

  // Unpack captured operands so the MAC operands are simple array selects.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack_i
      assign w_x_arr[gi] = r_x[gi*I_W +: I_W];
      for (genvar gj = 0; gj < N_OUT; gj++) begin : g_unpack_j
        assign w_w_arr[gi][gj] = r_w[(gi*N_OUT + gj)*I_W +: I_W];
      end
    end
  endgenerate

  dnn_mac_unit #(
    .I_W   (I_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_mac_clr),
    .i_en  (w_mac_en),
    .i_a   (w_x_arr[r_i]),
    .i_b   (w_w_arr[r_i][r_j]),
    .o_acc (w_acc)
  );

  assign w_j_is_last = (r_j == c_j_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_x     <= '0;
      r_w     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      if (w_capture) begin
        r_x <= in_x;
        r_w <= in_w;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_capture   = 1'b0;
    w_mac_clr   = 1'b0;
    w_mac_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_capture   = 1'b1;
          w_mac_clr   = 1'b1;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        w_mac_en = 1'b1;
        if (r_i == c_i_last) begin
          w_state_nxt = ST_EMIT;
        end else begin
          w_i_nxt = r_i + 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (w_j_is_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_j_nxt     = r_j + 1'b1;
            w_i_nxt     = '0;
            w_mac_clr   = 1'b1;
            w_state_nxt = ST_CALC;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef DNN_RELU_EN
  assign w_emit_data = w_acc[ACC_W-1] ? '0 : w_acc;
`else
  assign w_emit_data = w_acc;
`endif

  // Outputs decode directly from state so an async reset clears them at once.
  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_CALC) || (r_state == ST_EMIT);
  assign out_valid = (r_state == ST_EMIT);
  assign out_data  = out_valid ? w_emit_data : '0;
  assign out_idx   = out_valid ? r_j : '0;
  assign out_last  = out_valid && w_j_is_last;

endmodule
`default_nettype wire

// File: tb/tb_dnn_layer_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dnn_layer_seq
// Description : Directed self-checking bench for dnn_layer_seq (defaults
//               I_W=5, N_IN=4, N_OUT=4, ACC_W=12). Honours DNN_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dnn_layer_seq;

  localparam int I_W   = 5;
  localparam int N_IN  = 4;
  localparam int N_OUT = 4;
  localparam int ACC_W = 12;

  logic                      clk;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [N_IN*I_W-1:0]       in_x;
  logic [N_IN*N_OUT*I_W-1:0] in_w;
  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_W-1:0]          out_data;
  logic [1:0]                out_idx;
  logic                      out_last;
  logic                      busy;

  dnn_layer_seq #(
    .I_W   (I_W),
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Results gathered by run_batch
  int got_data [N_OUT];
  int got_idx  [N_OUT];
  int got_last [N_OUT];
  int hs_cyc   [N_OUT];
  int n_got;
  int first_valid_cyc;
  int ready_cyc;
  bit timeout;
  bit stable_ok;
  bit busy_ok;

  int wm [N_IN][N_OUT];

  function automatic int expv(input int v);
`ifdef DNN_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [N_IN*I_W-1:0] pack_x(input int a0, input int a1,
                                                  input int a2, input int a3);
    logic [N_IN*I_W-1:0] r;
    logic [31:0] t;
    t = a0; r[0*I_W +: I_W] = t[I_W-1:0];
    t = a1; r[1*I_W +: I_W] = t[I_W-1:0];
    t = a2; r[2*I_W +: I_W] = t[I_W-1:0];
    t = a3; r[3*I_W +: I_W] = t[I_W-1:0];
    return r;
  endfunction

  function automatic logic [N_IN*N_OUT*I_W-1:0] pack_wm();
    logic [N_IN*N_OUT*I_W-1:0] r;
    logic [31:0] t;
    r = '0;
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) begin
        t = wm[i][j];
        r[(i*N_OUT + j)*I_W +: I_W] = t[I_W-1:0];
      end
    return r;
  endfunction

  function automatic logic [N_IN*N_OUT*I_W-1:0] pack_w_all(input int v);
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) wm[i][j] = v;
    return pack_wm();
  endfunction

  // Offers one batch, then follows it to completion. Cycle numbers count
  // clock edges after the accepting edge. Optional stall of bp_len cycles
  // on neuron bp_idx, and optional competing in_valid while busy.
  task automatic run_batch(input logic [N_IN*I_W-1:0] x,
                           input logic [N_IN*N_OUT*I_W-1:0] w,
                           input int bp_idx, input int bp_len,
                           input bit inject,
                           input logic [N_IN*I_W-1:0] ix,
                           input logic [N_IN*N_OUT*I_W-1:0] iw);
    int cyc;
    int stall;
    logic [ACC_W-1:0] snap_d;
    logic [1:0] snap_i;
    timeout = 0; stable_ok = 1; busy_ok = 1; n_got = 0;
    first_valid_cyc = -1; ready_cyc = -1;
    snap_d = '0; snap_i = '0;
    for (int k = 0; k < N_OUT; k++) begin
      got_data[k] = -9999; got_idx[k] = -1; got_last[k] = -1; hs_cyc[k] = -1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 100 && in_ready !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    if (in_ready !== 1'b1) timeout = 1;
    in_valid = 1'b1; in_x = x; in_w = w;
    @(posedge clk); #1;
    in_valid = inject;
    in_x = inject ? ix : ~x;
    in_w = inject ? iw : ~w;
    cyc = 0; stall = 0;
    while (ready_cyc < 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (inject && n_got < N_OUT && in_ready !== 1'b0) busy_ok = 0;
      if (stall > 0 && stall < bp_len && out_valid !== 1'b1) stable_ok = 0;
      if (out_valid === 1'b1 && bp_idx >= 0 && int'(out_idx) == bp_idx && stall < bp_len) begin
        if (stall == 0) begin
          snap_d = out_data; snap_i = out_idx;
        end else if (out_data !== snap_d || out_idx !== snap_i) begin
          stable_ok = 0;
        end
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
        if (out_valid === 1'b1 && n_got < N_OUT) begin
          got_data[n_got] = int'($signed(out_data));
          got_idx[n_got]  = int'(out_idx);
          got_last[n_got] = int'(out_last);
          hs_cyc[n_got]   = cyc;
          n_got++;
        end
      end
      if (n_got == N_OUT && in_ready === 1'b1) ready_cyc = cyc;
    end
    if (ready_cyc < 0) timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_w = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (out_data !== '0 || out_idx !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: data=%0d idx=%0d last=%b, want 0 0 0", out_data, out_idx, out_last);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_unit_weights();
    run_batch(pack_x(1, 1, 1, 1), pack_w_all(1), -1, 0, 1'b0, '0, '0);
    checks++;
    if (timeout) begin
      errors++; $display("FAIL unit_timeout: batch did not complete, got %0d outputs, want %0d", n_got, N_OUT);
    end
    for (int k = 0; k < N_OUT; k++) begin
      checks++;
      if (got_data[k] != expv(4) || got_idx[k] != k || got_last[k] != ((k == N_OUT-1) ? 1 : 0)) begin
        errors++;
        $display("FAIL unit_out%0d: data=%0d idx=%0d last=%0d, want %0d %0d %0d",
                 k, got_data[k], got_idx[k], got_last[k], expv(4), k, (k == N_OUT-1) ? 1 : 0);
      end
    end
    checks++;
    if (first_valid_cyc != 4) begin
      errors++; $display("FAIL unit_latency: out_valid at cycle %0d, want 4", first_valid_cyc);
    end
    checks++;
    if (ready_cyc != 20) begin
      errors++; $display("FAIL unit_ready: in_ready at cycle %0d, want 20", ready_cyc);
    end
  endtask

  task automatic test_extremes();
    run_batch(pack_x(-16, -16, -16, -16), pack_w_all(-16), -1, 0, 1'b0, '0, '0);
    for (int k = 0; k < N_OUT; k++) begin
      checks++;
      if (timeout || got_data[k] != expv(1024) || got_idx[k] != k) begin
        errors++;
        $display("FAIL ext_pos%0d: data=%0d idx=%0d timeout=%0d, want %0d %0d", k, got_data[k], got_idx[k], timeout, expv(1024), k);
      end
    end
    run_batch(pack_x(-16, -16, -16, -16), pack_w_all(15), -1, 0, 1'b0, '0, '0);
    for (int k = 0; k < N_OUT; k++) begin
      checks++;
      if (timeout || got_data[k] != expv(-960) || got_idx[k] != k) begin
        errors++;
        $display("FAIL ext_neg%0d: data=%0d idx=%0d timeout=%0d, want %0d %0d", k, got_data[k], got_idx[k], timeout, expv(-960), k);
      end
    end
  endtask

  // x={3,-2,7,0}; columns: {1,1,1,1}->8, {-1,2,0,5}->-7,
  // {2,-3,1,-16}->19, {-16,15,-1,4}->-85
  task automatic load_mixed_w();
    wm[0][0] = 1;   wm[1][0] = 1;  wm[2][0] = 1;  wm[3][0] = 1;
    wm[0][1] = -1;  wm[1][1] = 2;  wm[2][1] = 0;  wm[3][1] = 5;
    wm[0][2] = 2;   wm[1][2] = -3; wm[2][2] = 1;  wm[3][2] = -16;
    wm[0][3] = -16; wm[1][3] = 15; wm[2][3] = -1; wm[3][3] = 4;
  endtask

  task automatic test_mixed();
    int exp_m [N_OUT];
    exp_m[0] = 8; exp_m[1] = -7; exp_m[2] = 19; exp_m[3] = -85;
    load_mixed_w();
    run_batch(pack_x(3, -2, 7, 0), pack_wm(), -1, 0, 1'b0, '0, '0);
    for (int k = 0; k < N_OUT; k++) begin
      checks++;
      if (timeout || got_data[k] != expv(exp_m[k]) || got_idx[k] != k) begin
        errors++;
        $display("FAIL mixed_out%0d: data=%0d idx=%0d timeout=%0d, want %0d %0d", k, got_data[k], got_idx[k], timeout, expv(exp_m[k]), k);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_m [N_OUT];
    exp_m[0] = 8; exp_m[1] = -7; exp_m[2] = 19; exp_m[3] = -85;
    load_mixed_w();
    run_batch(pack_x(3, -2, 7, 0), pack_wm(), 1, 5, 1'b0, '0, '0);
    checks++;
    if (!stable_ok) begin
      errors++; $display("FAIL bp_stable: outputs changed during stall, stable=%0d want 1", stable_ok);
    end
    checks++;
    if (got_data[1] != expv(-7) || got_idx[1] != 1) begin
      errors++; $display("FAIL bp_idx1: data=%0d idx=%0d, want %0d 1", got_data[1], got_idx[1], expv(-7));
    end
    checks++;
    if (hs_cyc[2] != 19 || got_idx[2] != 2 || got_data[2] != expv(19)) begin
      errors++;
      $display("FAIL bp_idx2: cycle=%0d idx=%0d data=%0d, want 19 2 %0d", hs_cyc[2], got_idx[2], got_data[2], expv(19));
    end
    checks++;
    if (timeout || ready_cyc != 25) begin
      errors++; $display("FAIL bp_ready: in_ready at cycle %0d, want 25", ready_cyc);
    end
  endtask

  task automatic test_busy_reject();
    int exp_m [N_OUT];
    int wait_cyc;
    exp_m[0] = 8; exp_m[1] = -7; exp_m[2] = 19; exp_m[3] = -85;
    load_mixed_w();
    run_batch(pack_x(3, -2, 7, 0), pack_wm(), -1, 0, 1'b1, pack_x(7, 7, 7, 7), pack_w_all(9));
    checks++;
    if (!busy_ok) begin
      errors++; $display("FAIL busy_ready: in_ready seen high while busy, ok=%0d want 1", busy_ok);
    end
    for (int k = 0; k < N_OUT; k++) begin
      checks++;
      if (timeout || got_data[k] != expv(exp_m[k])) begin
        errors++; $display("FAIL busy_out%0d: data=%0d, want %0d", k, got_data[k], expv(exp_m[k]));
      end
    end
    // in_valid is still high: the second batch is taken on this edge
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL busy_accept2: in_ready=%b busy=%b, want 0 1", in_ready, busy);
    end
    wait_cyc = 0;
    while (out_valid !== 1'b1 && wait_cyc < 50) begin
      @(posedge clk); #1; wait_cyc++;
    end
    checks++;
    if (wait_cyc != 4 || $signed(out_data) !== 12'(expv(252))) begin
      errors++; $display("FAIL busy_batch2: wait=%0d data=%0d, want 4 %0d", wait_cyc, $signed(out_data), expv(252));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 100 && in_ready !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int exp_m [N_OUT];
    exp_m[0] = 8; exp_m[1] = -7; exp_m[2] = 19; exp_m[3] = -85;
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = pack_x(-16, -16, -16, -16); in_w = pack_w_all(15);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_pre: busy=%b out_valid=%b, want 1 0", busy, out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL rmid_now: out_valid=%b busy=%b in_ready=%b data=%0d, want 0 0 1 0", out_valid, busy, in_ready, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    load_mixed_w();
    run_batch(pack_x(3, -2, 7, 0), pack_wm(), -1, 0, 1'b0, '0, '0);
    for (int k = 0; k < N_OUT; k++) begin
      checks++;
      if (timeout || got_data[k] != expv(exp_m[k]) || got_idx[k] != k) begin
        errors++;
        $display("FAIL rmid_out%0d: data=%0d idx=%0d, want %0d %0d", k, got_data[k], got_idx[k], expv(exp_m[k]), k);
      end
    end
    checks++;
    if (first_valid_cyc != 4 || ready_cyc != 20) begin
      errors++; $display("FAIL rmid_timing: valid=%0d ready=%0d, want 4 20", first_valid_cyc, ready_cyc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unit_weights();
    test_extremes();
    test_mixed();
    test_backpressure();
    test_busy_reject();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
